// File: rtl/stego_msg_pkg.sv
// Shared constants and state encoding for the hidden-message encoder/decoder paths.
package stego_msg_pkg;

  localparam int unsigned MSG_WORD_W       = 32;
  localparam int unsigned MSG_NIBBLE_W     = 4;
  localparam int unsigned NIBBLES_PER_WORD = MSG_WORD_W / MSG_NIBBLE_W;
  localparam int unsigned NIB_IDX_W        = $clog2(NIBBLES_PER_WORD);

  typedef enum logic {
    ASM_IDLE    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/decoder_msg_assembler.sv
// Packs decoded msg nibbles LSB-first into 32-bit words and pushes them into the msg output FIFO.
module decoder_msg_assembler
  import stego_msg_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS_PER_CIMG = 14400
) (
  input  logic                    decoder_clk,
  input  logic                    decoder_reset,
  input  logic [MSG_NIBBLE_W-1:0] decoded_nibble,
  input  logic                    decoded_nibble_valid,
  input  logic                    msg_flush,
  input  logic                    msg_outfifo_full,
  output logic                    msg_outfifo_wr_en,
  output logic [MSG_WORD_W-1:0]   msg_outfifo_din,
  output logic                    msg_asm_ready,
  output logic                    frame_done,
  output logic                    msg_overflow
);

  localparam int unsigned BLK_W = $clog2(NUM_BLOCKS_PER_CIMG + 1);

  asm_state_t            state_q, state_d;
  logic [MSG_WORD_W-1:0] asm_word_q, asm_word_d;
  logic [NIB_IDX_W-1:0]  nib_idx_q, nib_idx_d;
  logic [MSG_WORD_W-1:0] pend_word_q, pend_word_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  asm_ready_q, asm_ready_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;

  logic [MSG_WORD_W-1:0] merged_word;
  logic [MSG_WORD_W-1:0] commit_word;
  logic [BLK_W-1:0]      blk_next;
  logic                  commit;
  logic                  frame_end;

  // FIFO side is driven straight from the pend register.
  assign msg_outfifo_wr_en = pend_valid_q & ~msg_outfifo_full;
  assign msg_outfifo_din   = pend_word_q;
  assign msg_asm_ready     = asm_ready_q;
  assign frame_done        = frame_done_q;
  assign msg_overflow      = overflow_q;

  // Next-state: nibble absorption, flush/frame-end close-out and the single commit into pend.
  always_comb begin
    state_d      = state_q;
    asm_word_d   = asm_word_q;
    nib_idx_d    = nib_idx_q;
    pend_word_d  = pend_word_q;
    pend_valid_d = pend_valid_q;
    blk_cnt_d    = blk_cnt_q;
    asm_ready_d  = asm_ready_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    commit       = 1'b0;
    commit_word  = '0;

    merged_word = asm_word_q;
    merged_word[{nib_idx_q, 2'b00} +: MSG_NIBBLE_W] = decoded_nibble;
    blk_next  = blk_cnt_q + BLK_W'(1);
    frame_end = (blk_next == BLK_W'(NUM_BLOCKS_PER_CIMG));

    if (msg_outfifo_wr_en) begin
      pend_valid_d = 1'b0;
    end

    case (state_q)
      ASM_IDLE: begin
        if (decoded_nibble_valid) begin
          asm_word_d  = MSG_WORD_W'(decoded_nibble);
          nib_idx_d   = NIB_IDX_W'(1);
          blk_cnt_d   = BLK_W'(1);
          asm_ready_d = 1'b1;
          state_d     = ASM_COLLECT;
        end
      end
      ASM_COLLECT: begin
        if (decoded_nibble_valid) begin
          blk_cnt_d = blk_next;
          // A full word, a same-cycle flush, or frame end all close out the merged word once.
          if ((nib_idx_q == NIB_IDX_W'(NIBBLES_PER_WORD - 1)) || msg_flush || frame_end) begin
            commit      = 1'b1;
            commit_word = merged_word;
            asm_word_d  = '0;
            nib_idx_d   = '0;
          end else begin
            asm_word_d = merged_word;
            nib_idx_d  = nib_idx_q + NIB_IDX_W'(1);
          end
          if (frame_end) begin
            frame_done_d = 1'b1;
            asm_ready_d  = 1'b0;
            blk_cnt_d    = '0;
            state_d      = ASM_IDLE;
          end
        end else if (msg_flush && (nib_idx_q != '0)) begin
          commit      = 1'b1;
          commit_word = asm_word_q;
          asm_word_d  = '0;
          nib_idx_d   = '0;
        end
      end
      default: state_d = ASM_IDLE;
    endcase

    // Pend accepts a word only if it is empty or draining this cycle; otherwise the new word is lost.
    if (commit) begin
      if (!pend_valid_q || msg_outfifo_wr_en) begin
        pend_word_d  = commit_word;
        pend_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge decoder_clk) begin
    if (decoder_reset) begin
      state_q      <= ASM_IDLE;
      asm_word_q   <= '0;
      nib_idx_q    <= '0;
      pend_word_q  <= '0;
      pend_valid_q <= 1'b0;
      blk_cnt_q    <= '0;
      asm_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_word_q   <= asm_word_d;
      nib_idx_q    <= nib_idx_d;
      pend_word_q  <= pend_word_d;
      pend_valid_q <= pend_valid_d;
      blk_cnt_q    <= blk_cnt_d;
      asm_ready_q  <= asm_ready_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_decoder_msg_assembler.sv
// Directed bench for decoder_msg_assembler: vector table plus hand-written multi-cycle sequences.
module tb_decoder_msg_assembler;

  localparam int GAP = 64;

  logic        clk;
  logic        rst;
  logic [3:0]  nib;
  logic        nib_valid;
  logic        flush;
  logic        full;

  logic        wr_en, ready, fd, ovf;
  logic [31:0] din;
  logic        wr_en20, ready20, fd20, ovf20;
  logic [31:0] din20;

  decoder_msg_assembler dut (
    .decoder_clk          (clk),
    .decoder_reset        (rst),
    .decoded_nibble       (nib),
    .decoded_nibble_valid (nib_valid),
    .msg_flush            (flush),
    .msg_outfifo_full     (full),
    .msg_outfifo_wr_en    (wr_en),
    .msg_outfifo_din      (din),
    .msg_asm_ready        (ready),
    .frame_done           (fd),
    .msg_overflow         (ovf)
  );

  decoder_msg_assembler #(.NUM_BLOCKS_PER_CIMG(20)) dut20 (
    .decoder_clk          (clk),
    .decoder_reset        (rst),
    .decoded_nibble       (nib),
    .decoded_nibble_valid (nib_valid),
    .msg_flush            (flush),
    .msg_outfifo_full     (full),
    .msg_outfifo_wr_en    (wr_en20),
    .msg_outfifo_din      (din20),
    .msg_asm_ready        (ready20),
    .frame_done           (fd20),
    .msg_overflow         (ovf20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wr20_q[$];
  int          fd_cnt;
  int          fd20_cnt;

  // Record every FIFO write and frame_done pulse mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back(din);
      wr_cyc_q.push_back(cyc);
    end
    if (wr_en20) wr20_q.push_back(din20);
    if (fd) fd_cnt = fd_cnt + 1;
    if (fd20) fd20_cnt = fd20_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_strobe_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc_q.delete();
    wr20_q.delete();
    fd_cnt   = 0;
    fd20_cnt = 0;
  endtask

  // One nibble strobe (optionally with flush), followed by the rest of the block period.
  task automatic send_nib(input logic [3:0] n, input logic fl);
    nib       = n;
    nib_valid = 1'b1;
    flush     = fl;
    @(negedge clk);
    last_strobe_cyc = cyc;
    tick();
    nib_valid = 1'b0;
    flush     = 1'b0;
    repeat (GAP - 1) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    last_strobe_cyc = cyc;
    tick();
    flush = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic check_one_write(input string name, input logic [31:0] exp);
    check({name, "_count"}, 32'(wr_q.size()), 32'd1);
    check({name, "_word"}, (wr_q.size() > 0) ? wr_q[0] : ~exp, exp);
    check({name, "_lat"}, (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[0]) : 32'hFFFF_FFFF,
          32'(last_strobe_cyc + 1));
  endtask

  typedef struct {
    logic [31:0] nibs;
    int          n;
    logic        fl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   rel_cyc;

  initial begin
    rst       = 1'b1;
    nib       = 4'h0;
    nib_valid = 1'b0;
    flush     = 1'b0;
    full      = 1'b0;
    fd_cnt    = 0;
    fd20_cnt  = 0;

    vecs[0] = '{nibs: 32'h8765_4321, n: 8, fl: 1'b0, exp: 32'h8765_4321};
    vecs[1] = '{nibs: 32'h0000_0CBA, n: 3, fl: 1'b1, exp: 32'h0000_0CBA};
    vecs[2] = '{nibs: 32'hDEAD_BEEF, n: 8, fl: 1'b0, exp: 32'hDEAD_BEEF};
    vecs[3] = '{nibs: 32'h0000_0005, n: 1, fl: 1'b1, exp: 32'h0000_0005};
    vecs[4] = '{nibs: 32'h0123_4567, n: 7, fl: 1'b1, exp: 32'h0123_4567};

    repeat (3) tick();
    do_reset();
    check("reset_outputs", {26'd0, wr_en, ready, fd, ovf, 2'b00}, 32'd0);
    check("reset_din", din, 32'd0);
    check("reset_outputs20", {27'd0, wr_en20, ready20, fd20, ovf20, 1'b0}, 32'd0);

    // Table: words built from nibble sequences, closed by completion or flush.
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      for (int k = 0; k < vecs[v].n; k++) begin
        logic [31:0] w;
        w = vecs[v].nibs >> (4 * k);
        send_nib(w[3:0], 1'b0);
        if (v == 0 && k == 0) check("ready_after_first", 32'(ready), 32'd1);
      end
      if (vecs[v].fl) do_flush();
      check_one_write($sformatf("vec%0d", v), vecs[v].exp);
      check($sformatf("vec%0d_ready", v), 32'(ready), 32'd1);
    end

    // Flush on an empty word is a no-op.
    clear_mon();
    do_flush();
    check("empty_flush_count", 32'(wr_q.size()), 32'd0);

    // Eighth nibble with flush in the same cycle: only the full word.
    clear_mon();
    for (int k = 0; k < 7; k++) send_nib(4'h9, 1'b0);
    send_nib(4'hA, 1'b1);
    repeat (8) tick();
    check_one_write("nib7_flush", 32'hA999_9999);

    // Mid-word nibble with flush: nibble absorbed, then padded.
    clear_mon();
    send_nib(4'h3, 1'b0);
    send_nib(4'h4, 1'b0);
    send_nib(4'h5, 1'b1);
    check_one_write("nib_flush_partial", 32'h0000_0543);

    // Backpressure: second word dropped while pend holds the first.
    clear_mon();
    full = 1'b1;
    for (int k = 0; k < 8; k++) send_nib(4'h1, 1'b0);
    check("full_no_write_1", 32'(wr_q.size()), 32'd0);
    check("full_no_ovf_yet", 32'(ovf), 32'd0);
    for (int k = 0; k < 8; k++) send_nib(4'h2, 1'b0);
    repeat (GAP) tick();
    check("full_no_write_2", 32'(wr_q.size()), 32'd0);
    check("ovf_set", 32'(ovf), 32'd1);
    full = 1'b0;
    @(negedge clk);
    rel_cyc = cyc;
    tick();
    repeat (20) tick();
    check("full_release_count", 32'(wr_q.size()), 32'd1);
    check("full_release_word", (wr_q.size() > 0) ? wr_q[0] : 32'd0, 32'h1111_1111);
    check("full_release_cyc", (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[0]) : 32'hFFFF_FFFF,
          32'(rel_cyc));
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-frame discards the partial word.
    do_reset();
    check("ovf_cleared", 32'(ovf), 32'd0);
    for (int k = 0; k < 5; k++) send_nib(4'hC, 1'b0);
    rst = 1'b1;
    tick();
    check("midreset_outputs", {27'd0, wr_en, ready, fd, ovf, 1'b0}, 32'd0);
    check("midreset_din", din, 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("midreset_no_write", 32'(wr_q.size()), 32'd0);
    clear_mon();
    for (int k = 0; k < 8; k++) send_nib(4'(k), 1'b0);
    check_one_write("post_reset", 32'h7654_3210);

    // Frame end on the 20-block instance.
    do_reset();
    for (int k = 0; k < 20; k++) send_nib(4'hF, 1'b0);
    repeat (4) tick();
    check("frame_count", 32'(wr20_q.size()), 32'd3);
    check("frame_w0", (wr20_q.size() > 0) ? wr20_q[0] : 32'd0, 32'hFFFF_FFFF);
    check("frame_w1", (wr20_q.size() > 1) ? wr20_q[1] : 32'd0, 32'hFFFF_FFFF);
    check("frame_w2", (wr20_q.size() > 2) ? wr20_q[2] : 32'd0, 32'h0000_FFFF);
    check("frame_done_once", 32'(fd20_cnt), 32'd1);
    check("frame_ready_low", 32'(ready20), 32'd0);
    check("big_frame_no_done", 32'(fd_cnt), 32'd0);
    check("big_frame_writes", 32'(wr_q.size()), 32'd2);
    check("big_frame_ready", 32'(ready), 32'd1);
    wr20_q.delete();
    send_nib(4'hE, 1'b0);
    check("new_frame_ready", 32'(ready20), 32'd1);
    do_flush();
    check("new_frame_count", 32'(wr20_q.size()), 32'd1);
    check("new_frame_word", (wr20_q.size() > 0) ? wr20_q[0] : 32'd0, 32'h0000_000E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
